// File: rtl/dct_quant_pkg.sv
// Shared constants and helpers for the DCT quantiser multiplier.
package dct_quant_pkg;

  localparam int DEF_A_W   = 12;
  localparam int DEF_B_W   = 8;
  localparam int DEF_OUT_W = 9;
  localparam int DEF_SHIFT = 11;

  // Half-LSB offset added before the right shift, or zero when truncating.
  function automatic int unsigned round_const(input int shift, input bit round_en);
    int unsigned rc;
    if (round_en && (shift > 0)) begin
      rc = 32'd1 << (shift - 1);
    end else begin
      rc = 32'd0;
    end
    return rc;
  endfunction

  // Largest positive magnitude representable in an out_w-bit signed value.
  function automatic int unsigned sat_pos_limit(input int out_w);
    return (32'd1 << (out_w - 1)) - 32'd1;
  endfunction

  // Largest negative magnitude representable in an out_w-bit signed value.
  function automatic int unsigned sat_neg_limit(input int out_w);
    return 32'd1 << (out_w - 1);
  endfunction

  localparam int unsigned DEF_SAT_POS = sat_pos_limit(DEF_OUT_W);
  localparam int unsigned DEF_SAT_NEG = sat_neg_limit(DEF_OUT_W);

endpackage

// File: rtl/umult_pipe.sv
// Unsigned A_W x B_W multiplier. The partial products of B are split into
// STAGES equal groups; each stage adds its group to the running sum and
// registers it. Valid and a small tag ride alongside the data.
module umult_pipe #(
  parameter int A_W    = 12,
  parameter int B_W    = 8,
  parameter int STAGES = 4,
  parameter int TAG_W  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  output logic [A_W+B_W-1:0]   prod,
  output logic [TAG_W-1:0]     out_tag,
  output logic [STAGES-1:0]    valid_bits
);

  localparam int P_W  = A_W + B_W;
  localparam int GRP  = (B_W + STAGES - 1) / STAGES;
  localparam int OP_N = (STAGES > 1) ? STAGES - 1 : 1;

  logic [P_W-1:0]   acc_reg [STAGES];
  logic [P_W-1:0]   acc_nxt [STAGES];
  logic [TAG_W-1:0] tag_reg [STAGES];
  logic [STAGES-1:0] v_reg;
  logic [A_W-1:0]   a_reg [OP_N];
  logic [B_W-1:0]   b_reg [OP_N];
  logic [A_W-1:0]   a_op  [STAGES];
  logic [B_W-1:0]   b_op  [STAGES];

  // Per-stage partial sum: previous stage's sum plus this stage's group of
  // shifted partial products.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        a_op[s]    = a;
        b_op[s]    = b;
        acc_nxt[s] = '0;
      end else begin
        a_op[s]    = a_reg[(s > 0) ? s - 1 : 0];
        b_op[s]    = b_reg[(s > 0) ? s - 1 : 0];
        acc_nxt[s] = acc_reg[(s > 0) ? s - 1 : 0];
      end
      for (int i = 0; i < B_W; i++) begin
        if (((i / GRP) == s) && b_op[s][i]) begin
          acc_nxt[s] = acc_nxt[s] + (P_W'(a_op[s]) << i);
        end else begin
          acc_nxt[s] = acc_nxt[s];
        end
      end
    end
  end

  // Stage registers: sums, operands for later groups, valid and tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg <= '0;
      for (int s = 0; s < STAGES; s++) begin
        acc_reg[s] <= '0;
        tag_reg[s] <= '0;
      end
      for (int s = 0; s < OP_N; s++) begin
        a_reg[s] <= '0;
        b_reg[s] <= '0;
      end
    end else if (!stall) begin
      v_reg[0]   <= in_valid;
      tag_reg[0] <= in_tag;
      a_reg[0]   <= a;
      b_reg[0]   <= b;
      for (int s = 0; s < STAGES; s++) begin
        acc_reg[s] <= acc_nxt[s];
      end
      for (int s = 1; s < STAGES; s++) begin
        v_reg[s]   <= v_reg[s-1];
        tag_reg[s] <= tag_reg[s-1];
      end
      for (int s = 1; s < OP_N; s++) begin
        a_reg[s] <= a_reg[s-1];
        b_reg[s] <= b_reg[s-1];
      end
    end
  end

  assign out_valid  = v_reg[STAGES-1];
  assign prod       = acc_reg[STAGES-1];
  assign out_tag    = tag_reg[STAGES-1];
  assign valid_bits = v_reg;

endmodule

// File: rtl/dct_quant_mult_pipe.sv
// DCT quantiser: sign-magnitude multiply by the quantiser reciprocal, round,
// re-apply sign and saturate. Input register, multiplier core, output register.
module dct_quant_mult_pipe
  import dct_quant_pkg::*;
#(
  parameter int A_W      = DEF_A_W,
  parameter int B_W      = DEF_B_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int STAGES   = 4,
  parameter int ROUND_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [A_W-1:0]   in_data,
  input  logic [B_W-1:0]   in_qfactor,
  input  logic             in_last,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_sat,
  output logic             busy
);

  localparam int P_W = A_W + B_W;
  localparam int R_W = P_W + 1;
  localparam logic [R_W-1:0]   RND_C   = R_W'(round_const(SHIFT, ROUND_EN != 0));
  localparam logic [R_W-1:0]   POS_LIM = R_W'(sat_pos_limit(OUT_W));
  localparam logic [R_W-1:0]   NEG_LIM = R_W'(sat_neg_limit(OUT_W));
  localparam logic [OUT_W-1:0] POS_MAX = OUT_W'(sat_pos_limit(OUT_W));
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic              s0_valid;
  logic [A_W-1:0]    s0_mag;
  logic [B_W-1:0]    s0_qf;
  logic              s0_sign;
  logic              s0_zero;
  logic              s0_last;

  logic              core_valid;
  logic [P_W-1:0]    core_prod;
  logic              core_last;
  logic [STAGES-1:0] core_vbits;

  logic [STAGES-1:0] sign_sr;
  logic [STAGES-1:0] zero_sr;

  logic [R_W-1:0]    rsum;
  logic [R_W-1:0]    rmag;
  logic [OUT_W-1:0]  res;
  logic              res_sat;

  // Input register: split the coefficient into sign and magnitude.
  // The most negative coefficient maps to magnitude 2^(A_W-1), which still
  // fits an A_W-bit unsigned value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_mag   <= '0;
      s0_qf    <= '0;
      s0_sign  <= 1'b0;
      s0_zero  <= 1'b0;
      s0_last  <= 1'b0;
    end else if (!stall) begin
      s0_valid <= in_valid;
      s0_mag   <= in_data[A_W-1] ? (-in_data) : in_data;
      s0_qf    <= in_qfactor;
      s0_sign  <= in_data[A_W-1];
      s0_zero  <= (in_data == '0) || (in_qfactor == '0);
      s0_last  <= in_last;
    end
  end

  umult_pipe #(
    .A_W    (A_W),
    .B_W    (B_W),
    .STAGES (STAGES),
    .TAG_W  (1)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .in_valid   (s0_valid),
    .a          (s0_mag),
    .b          (s0_qf),
    .in_tag     (s0_last),
    .out_valid  (core_valid),
    .prod       (core_prod),
    .out_tag    (core_last),
    .valid_bits (core_vbits)
  );

  // Sign/zero side pipeline, same depth as the multiplier core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_sr <= '0;
      zero_sr <= '0;
    end else if (!stall) begin
      sign_sr[0] <= s0_sign;
      zero_sr[0] <= s0_zero;
      for (int i = 1; i < STAGES; i++) begin
        sign_sr[i] <= sign_sr[i-1];
        zero_sr[i] <= zero_sr[i-1];
      end
    end
  end

  // Round, re-apply sign and clip; zero results are forced positive.
  always_comb begin
    rsum    = {1'b0, core_prod} + RND_C;
    rmag    = rsum >> SHIFT;
    res     = '0;
    res_sat = 1'b0;
    if (zero_sr[STAGES-1] || (rmag == '0)) begin
      res     = '0;
      res_sat = 1'b0;
    end else if (!sign_sr[STAGES-1]) begin
      if (rmag > POS_LIM) begin
        res     = POS_MAX;
        res_sat = 1'b1;
      end else begin
        res     = rmag[OUT_W-1:0];
        res_sat = 1'b0;
      end
    end else begin
      if (rmag > NEG_LIM) begin
        res     = NEG_MIN;
        res_sat = 1'b1;
      end else begin
        res     = -rmag[OUT_W-1:0];
        res_sat = 1'b0;
      end
    end
  end

  // Output register; data, sat and last are zero whenever valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      out_valid <= core_valid;
      out_data  <= core_valid ? res : '0;
      out_last  <= core_valid & core_last;
      out_sat   <= core_valid & res_sat;
    end
  end

  assign busy = s0_valid | (|core_vbits) | out_valid;

endmodule
